// File: rtl/cache_pkg.sv
// cache_pkg: fill FSM state type, cache geometry and tag_in field positions
package cache_pkg;
  localparam int BLOCK_WORDS = 8;
  localparam int ADDR_W = 16;
  localparam int TAG_W = 6;
  localparam int SET_W = 6;
  localparam int OFFSET_W = 4;
  localparam int TAG_MSB = 7;
  localparam int TAG_LSB = 2;
  localparam int VALID_BIT = 1;
  typedef enum logic [1:0] {IDLE, FILL, TAG} fill_state_t;
endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss inputs, memory request/return and cache write ports; master=fill FSM, slave=cache/memory side
interface cache_fill_fsm_if;
  import cache_pkg::*;
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [15:0]       memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] memory_address;
  logic [ADDR_W-1:0] cache_addr;
  logic [15:0]       data_in;
  logic              write_data_array;
  logic [7:0]        tag_in;
  logic              write_tag_array;
  modport master(
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_en, memory_address, cache_addr, data_in, write_data_array, tag_in, write_tag_array
  );
  modport slave(
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_en, memory_address, cache_addr, data_in, write_data_array, tag_in, write_tag_array
  );
endinterface

// File: rtl/fill_word_counter.sv
// fill_word_counter: 3-bit word counter (clk, rst, i_clr, i_en -> o_cnt, o_last when cnt==7)
module fill_word_counter
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [2:0] o_cnt,
  output logic       o_last
);
  logic [2:0] r_cnt;
  always_ff @(posedge clk) r_cnt <= (rst || i_clr) ? 3'd0 : i_en ? r_cnt + 3'd1 : r_cnt;
  assign o_cnt  = r_cnt;
  assign o_last = r_cnt == 3'(BLOCK_WORDS - 1);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-fill controller (clk, rst, bus master: 8 word reads, 8 data writes, 1 tag write)
module cache_fill_fsm
  import cache_pkg::*;
(
  input logic              clk,
  input logic              rst,
  cache_fill_fsm_if.master bus
);
  fill_state_t              r_state, w_next;
  logic [TAG_W+SET_W-1:0]   r_line;
  logic                     r_issue_done;
  logic                     w_accept, w_wr, w_issue_last, w_recv_last;
  logic [2:0]               w_issue_cnt, w_recv_cnt;
  logic [7:0]               w_tag;
  fill_word_counter u_issue (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(bus.mem_en),
    .o_cnt(w_issue_cnt), .o_last(w_issue_last)
  );
  fill_word_counter u_recv (
    .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_wr),
    .o_cnt(w_recv_cnt), .o_last(w_recv_last)
  );
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE ? (w_accept ? FILL : IDLE) :
             r_state == FILL ? ((w_wr && w_recv_last) ? TAG : FILL) : IDLE;
  always_ff @(posedge clk) begin
    r_issue_done <= (rst || w_accept) ? 1'b0 : (bus.mem_en && w_issue_last) ? 1'b1 : r_issue_done;
    r_line       <= rst ? '0 : w_accept ? bus.miss_address[ADDR_W-1:OFFSET_W] : r_line;
  end
  always_comb begin
    w_accept                    = r_state == IDLE && bus.miss_detected;
    w_wr                        = r_state == FILL && bus.memory_data_valid;
    w_tag                       = '0;
    w_tag[TAG_MSB:TAG_LSB]      = r_line[TAG_W+SET_W-1 -: TAG_W];
    w_tag[VALID_BIT]            = 1'b1;
    bus.fsm_busy                = r_state != IDLE;
    bus.mem_en                  = r_state == FILL && !r_issue_done;
    bus.memory_address          = {r_line, w_issue_cnt, 1'b0};
    // recv counter has wrapped to 0 by TAG, so cache_addr falls back to base
    bus.cache_addr              = {r_line, w_recv_cnt, 1'b0};
    bus.data_in                 = bus.memory_data;
    bus.write_data_array        = w_wr;
    bus.tag_in                  = w_tag;
    bus.write_tag_array         = r_state == TAG;
  end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller sitting between the 2KB 2-way set-associative I/D-cache and pipelined main memory. On a cache miss it latches the block-aligned miss address and issues eight sequential word reads to memory. It writes each returned word into the cache data array, then performs a single tag-array write that installs the new tag as valid. It drives the cache's data_in/write_data_array/tag_in/write_tag_array port set and stalls the pipeline via fsm_busy.

## Interface
- BLOCK_WORDS, 8, words per 16-byte cache line; only 8 supported (3-bit word counters)
- ADDR_W, 16, byte-address width
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- miss_detected  in  1  cache reports miss this cycle; sampled only in IDLE
- miss_address  in  16  byte address of the missing access
- memory_data  in  16  word returned by memory
- memory_data_valid  in  1  memory_data valid this cycle; returns in request order
- fsm_busy  out  1  fill in progress (state != IDLE); stalls pipeline
- mem_en  out  1  read request to memory this cycle
- memory_address  out  16  request address {base[15:4], issue_cnt, 1'b0}
- cache_addr  out  16  cache index/offset for current write {base[15:4], recv_cnt, 1'b0}
- data_in  out  16  equals memory_data
- write_data_array  out  1  write data_in into cache at cache_addr
- tag_in  out  8  {base[15:10], 1'b1 (valid), 1'b0}
- write_tag_array  out  1  install tag for set base[9:4]

## Operation
- States: IDLE, FILL, TAG.
- IDLE: on miss_detected, latch base = {miss_address[15:4], 4'h0}, clear issue_cnt and recv_cnt, go to FILL. memory_data_valid is ignored in IDLE.
- FILL, request side: mem_en=1 while issue_done=0. Each cycle with mem_en, issue_cnt increments. When issue_cnt=7 is issued, issue_done is set and mem_en drops.
- FILL, receive side: write_data_array = memory_data_valid, combinational. On each valid word recv_cnt increments. The valid with recv_cnt=7 writes the last word and moves to TAG.
- TAG: write_tag_array=1 for exactly one cycle, then return to IDLE.
- write_data_array and write_tag_array are never high in the same cycle. The cache gives data writes priority over tag writes, so the tag write needs its own cycle.
- Word counters are 3 bits; no wrap beyond 7 is reachable. issue_cnt saturates via issue_done.
- Extra memory_data_valid in TAG/IDLE is ignored, with no write.
- miss_detected in FILL/TAG is ignored. base does not change until the next IDLE acceptance.
- tag_in and cache_addr are stable from base for the whole fill. cache_addr=base during TAG.

## Timing
- Reset values: all outputs 0 except memory_address/cache_addr/tag_in = derived from base=0 (tag_in=8'h02); state IDLE; counters 0; issue_done 0.
- Reset mid-fill: next cycle state IDLE and all strobes 0. Outstanding memory returns are ignored.
- Miss sampled at edge N: fsm_busy=1 and first request (word 0) in cycle N+1. Requests cover N+1..N+8.
- With memory latency L (4 nominal), data writes occur N+1+L .. N+8+L.
- Tag write occurs in cycle N+9+L. fsm_busy=0 from N+10+L, so a nominal fill is 14 cycles from miss to idle.
- Data-valid gaps are tolerated; the FSM waits in FILL indefinitely.
- Back-to-back misses: a miss asserted in the first IDLE cycle after TAG is accepted.

## Structure
- Shared package cache_pkg holds fill_state_t (IDLE/FILL/TAG) and constants: BLOCK_WORDS, TAG_W=6, SET_W=6, OFFSET_W=4, and the tag_in field positions (tag [7:2], valid [1]).
- Sub-module fill_word_counter: 3-bit counter with clr/en and terminal flag (cnt==7). Instantiated twice, as issue and receive counters.

## Test plan
- Miss at 16'hABCD, L=4: requests 16'hABC0..16'hABCE in 8 consecutive cycles. Data written at cache_addr ABC0..ABCE. tag_in=8'hAA ({6'h2A,1,0}) with one write_tag_array. Busy for 13 cycles.
- Valid gaps (valid 1,0,0,1…): exactly 8 data writes, each to the next offset. Tag write only after the 8th.
- miss_detected held high throughout and a new miss_address mid-fill: base unchanged, no restart. Next fill starts the cycle after returning to IDLE.
- rst asserted at 4th returned word: next cycle fsm_busy=0, no writes. Remaining valid pulses are ignored. A fresh miss completes normally.
- Spurious memory_data_valid in IDLE and in TAG: no write_data_array. write_data_array & write_tag_array are never both 1 (assertion).
